// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: decode-side controls, instruction-memory read port, decode handshake.
// Pure wiring, no storage, so it adds no latency.
// Backpressure travels on instr_ready. The memory port has no ready signal and is paced by the fetch unit's credit check.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    // Fetch unit side: drives the memory request and the decode stream
    modport master (
        input  fetch_en, redirect_valid, redirect_pc, mem_data, mem_valid, instr_ready,
        output mem_rd_en, mem_rd_addr, instr_valid, instr, instr_pc
    );

    // Environment side: memory responder plus decode stage
    modport slave (
        output fetch_en, redirect_valid, redirect_pc, mem_data, mem_valid, instr_ready,
        input  mem_rd_en, mem_rd_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Owns the PC and issues word reads. Responses are buffered as {pc, instr} and handed to decode on valid/ready.
// Latency: a read issued in cycle N returns in N+1, and the instruction is visible to decode from N+2.
// Backpressure: a read issues only when the buffer has a free slot for its response, so no response is ever dropped.
module instruction_fetch_unit #(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic              r_in_flight;
    logic [ADDR_W-1:0] r_in_flight_pc;
    logic [ADDR_W-1:0] r_fifo_pc  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_dat [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_committed;
    logic [ADDR_W-1:0] w_redirect_pc;

    // Buffer slots already claimed: entries held plus the read in flight, minus the entry leaving this cycle
    assign w_pop         = (r_count != '0) & bus.instr_ready;
    assign w_push        = bus.mem_valid & r_in_flight;
    assign w_committed   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_in_flight} - {{CNT_W{1'b0}}, w_pop};
    assign w_issue       = bus.fetch_en & ~rst & ~bus.redirect_valid
                         & (w_committed < (CNT_W+1)'(FIFO_DEPTH));
    assign w_redirect_pc = bus.redirect_pc & ~ADDR_W'(3);

    assign bus.mem_rd_en   = w_issue;
    assign bus.mem_rd_addr = r_pc;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr       = r_fifo_dat[r_rd_ptr];
    assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];

    // PC, in-flight tracking and buffer update. Reset beats redirect, and redirect beats issue, push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_in_flight    <= 1'b0;
            r_in_flight_pc <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]  <= '0;
                r_fifo_dat[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Dropping in_flight makes the next response land as a stray and be discarded
            r_pc        <= w_redirect_pc;
            r_in_flight <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_issue) begin
                r_in_flight    <= 1'b1;
                r_in_flight_pc <= r_pc;
                r_pc           <= r_pc + ADDR_W'(4);
            end else begin
                r_in_flight    <= 1'b0;
            end
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]  <= r_in_flight_pc;
                r_fifo_dat[r_wr_ptr] <= bus.mem_data;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule
